ctrl_fsm_multicycle: RTL
========================

Name: ctrl_fsm_multicycle

Overview:
Parametrised multi-cycle control unit for the accumulator datapath (A and G registers, register file, add/sub ALU, display latch). It now owns the program counter and instruction register, and fetches through a req/ack instruction-memory handshake that tolerates wait states. It decodes a 4-bit opcode space that adds JMP, BEQZ and NOP, and flags illegal opcodes. Sits between instruction memory and the datapath; all datapath strobes are Moore outputs of the current state.

Parameters:
REG_AW, 2, register-index field width (2^REG_AW registers)
IMM_W, 8, immediate field width
PC_W, 8, program counter width
RESET_PC, 0, PC value after reset
(derived, not overridable) INSTR_W = 4 + 2*REG_AW + IMM_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
imem_req  out  1  fetch request; held until imem_ack
imem_ack  in  1  instruction valid on imem_rdata this cycle
imem_rdata  in  INSTR_W  instruction word: [INSTR_W-1:INSTR_W-4] opcode, then rx (REG_AW bits), then ry (REG_AW bits), then imm [IMM_W-1:0]
pc  out  PC_W  current fetch address
rx_sel, ry_sel  out  REG_AW  register-index fields from IR
imm  out  IMM_W  immediate field from IR
bus_zero  in  1  datapath bus equals zero (sampled in BRANCH)
_Extern, Gout, Iout, Ain, Gin, DPin, RdX, RdY, WrX, add_sub  out  1  datapath strobes
halted  out  1  high in HALT
illegal  out  1  sticky: HALT was entered on an unimplemented opcode
cur_state  out  4  state encoding, for debug

Behaviour:
- Reset (async): state=FETCH, pc=RESET_PC, IR=0, illegal=0. All strobes are 0, imem_req=1 (FETCH outputs), halted=0.
- Reset mid-fetch aborts the fetch. Memory must accept a request that restarts with no gap.
- State encodings: FETCH=0, DECODE=1, LOAD=2, READ_X=3, READ_Y=4, ADD=5, SUB=6, MV=7, ADDI=8, SUBI=9, WRITE_X=10, DISP=11, JUMP=12, BRANCH=13, HALT=14.
- FETCH: imem_req=1. On imem_ack: IR<=imem_rdata, pc<=pc+1 (mod 2^PC_W), go to DECODE. Otherwise stay in FETCH; wait states are unbounded.
- Opcode sequences (strobes are high only in the named state; every other strobe is 0):
  - 0000 LOAD: LOAD(_Extern, WrX) -> FETCH
  - 0011 ADD: READ_Y(Ain, RdY) -> ADD(Gin, RdX) -> WRITE_X(Gout, WrX) -> FETCH
  - 0001 MV: READ_Y(Ain, RdY) -> MV(Gin; no read; add_sub=0) -> WRITE_X
  - 0010 SUB: READ_X(Ain, RdX) -> SUB(Gin, RdY, add_sub) -> WRITE_X
  - 0111 ADDI: READ_X -> ADDI(Iout, Gin) -> WRITE_X
  - 0110 SUBI: READ_X -> SUBI(Iout, Gin, add_sub) -> WRITE_X
  - 0100 DISP: DISP(DPin, RdX) -> FETCH
  - 1000 JMP: JUMP (no strobes): pc<=imm -> FETCH
  - 1001 BEQZ: BRANCH(RdX): if bus_zero then pc<=imm -> FETCH
  - 1010 NOP: DECODE -> FETCH
  - 0101 HALT: -> HALT
  - 1011..1111: -> HALT with illegal<=1
- Branch/jump target: imm zero-extended or truncated to PC_W bits.
- READ_X and READ_Y branch on the IR opcode. IR is stable from DECODE until the next imem_ack.
- HALT: all strobes 0, imem_req=0, halted=1, pc frozen. Only reset exits HALT.
- Any undefined state encoding -> FETCH on the next clock.
- Instruction cycle counts, including FETCH with zero wait states: LOAD/DISP/JMP/BEQZ 3; ADD/SUB/MV/ADDI/SUBI 5; NOP 2.
- imem_ack outside FETCH is ignored.

Test Plan:
- Reset, then imem_ack in 1st FETCH cycle with ADD (rx=1, ry=2) -> states FETCH, DECODE, READ_Y, ADD, WRITE_X, FETCH; pc 0->1; RdY+Ain in cycle 3, Gin+RdX in cycle 4, Gout+WrX in cycle 5.
- FETCH with imem_ack delayed 3 cycles -> imem_req held 4 cycles, pc unchanged until the ack, IR captures only the acked word.
- BEQZ imm=0x40 with bus_zero=1 -> pc=0x40 at the next FETCH. Repeat with bus_zero=0 -> pc=old+1.
- JMP imm=0xFF, then a fetch at 0xFF -> pc wraps to 0x00 after the ack. SUBI -> add_sub=1 with Iout and Gin together.
- Opcode 1100 -> HALT, halted=1, illegal=1, imem_req=0 for 20 cycles. Then reset -> illegal=0, pc=RESET_PC.
- Assert reset in ADD state and in FETCH mid-wait -> state=FETCH immediately (async), all strobes 0.

Source files
------------

// File: rtl/ctrl_fsm_multicycle.sv
// Multi-cycle control unit for the accumulator datapath: owns PC and IR, fetches over a
// req/ack instruction-memory handshake and sequences the datapath strobes as Moore outputs.
`timescale 1ns/1ps

module ctrl_fsm_multicycle #(
    parameter int REG_AW   = 2,
    parameter int IMM_W    = 8,
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    input  logic                         imem_ack,
    input  logic [4+2*REG_AW+IMM_W-1:0]  imem_rdata,
    output logic [PC_W-1:0]              pc,
    output logic [REG_AW-1:0]            rx_sel,
    output logic [REG_AW-1:0]            ry_sel,
    output logic [IMM_W-1:0]             imm,
    input  logic                         bus_zero,
    output logic                         _Extern,
    output logic                         Gout,
    output logic                         Iout,
    output logic                         Ain,
    output logic                         Gin,
    output logic                         DPin,
    output logic                         RdX,
    output logic                         RdY,
    output logic                         WrX,
    output logic                         add_sub,
    output logic                         halted,
    output logic                         illegal,
    output logic [3:0]                   cur_state
);

    localparam int INSTR_W = 4 + 2*REG_AW + IMM_W;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_MV   = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_DISP = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b0101;
    localparam logic [3:0] OP_SUBI = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BEQZ = 4'b1001;
    localparam logic [3:0] OP_NOP  = 4'b1010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_LOAD    = 4'd2,
        S_READ_X  = 4'd3,
        S_READ_Y  = 4'd4,
        S_ADD     = 4'd5,
        S_SUB     = 4'd6,
        S_MV      = 4'd7,
        S_ADDI    = 4'd8,
        S_SUBI    = 4'd9,
        S_WRITE_X = 4'd10,
        S_DISP    = 4'd11,
        S_JUMP    = 4'd12,
        S_BRANCH  = 4'd13,
        S_HALT    = 4'd14
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [INSTR_W-1:0]   ir;
    logic [3:0]           opcode;
    logic                 op_illegal;
    logic [PC_W-1:0]      target;

    assign opcode     = ir[INSTR_W-1 -: 4];
    assign rx_sel     = ir[INSTR_W-5 -: REG_AW];
    assign ry_sel     = ir[IMM_W+REG_AW-1 -: REG_AW];
    assign imm        = ir[IMM_W-1:0];
    assign op_illegal = (opcode > OP_NOP);
    // Size cast zero-extends or truncates the immediate to the PC width.
    assign target     = PC_W'(imm);
    assign cur_state  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // PC and IR move only on an accepted fetch or a taken jump/branch, so HALT freezes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= PC_W'(RESET_PC);
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            if (state == S_FETCH && imem_ack) begin
                ir <= imem_rdata;
                pc <= pc + PC_W'(1);
            end else if (state == S_JUMP || (state == S_BRANCH && bus_zero)) begin
                pc <= target;
            end
            if (state == S_DECODE && op_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        halted     = 1'b0;
        _Extern    = 1'b0;
        Gout       = 1'b0;
        Iout       = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        DPin       = 1'b0;
        RdX        = 1'b0;
        RdY        = 1'b0;
        WrX        = 1'b0;
        add_sub    = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD:                  next_state = S_LOAD;
                    OP_ADD, OP_MV:            next_state = S_READ_Y;
                    OP_SUB, OP_ADDI, OP_SUBI: next_state = S_READ_X;
                    OP_DISP:                  next_state = S_DISP;
                    OP_JMP:                   next_state = S_JUMP;
                    OP_BEQZ:                  next_state = S_BRANCH;
                    OP_NOP:                   next_state = S_FETCH;
                    OP_HALT:                  next_state = S_HALT;
                    default:                  next_state = S_HALT;
                endcase
            end
            S_LOAD: begin
                _Extern    = 1'b1;
                WrX        = 1'b1;
                next_state = S_FETCH;
            end
            // SUB/ADDI/SUBI latch rx into A first; ADD/MV latch ry.
            S_READ_X: begin
                Ain = 1'b1;
                RdX = 1'b1;
                case (opcode)
                    OP_SUB:  next_state = S_SUB;
                    OP_ADDI: next_state = S_ADDI;
                    OP_SUBI: next_state = S_SUBI;
                    default: next_state = S_FETCH;
                endcase
            end
            S_READ_Y: begin
                Ain = 1'b1;
                RdY = 1'b1;
                case (opcode)
                    OP_ADD:  next_state = S_ADD;
                    OP_MV:   next_state = S_MV;
                    default: next_state = S_FETCH;
                endcase
            end
            S_ADD: begin
                Gin        = 1'b1;
                RdX        = 1'b1;
                next_state = S_WRITE_X;
            end
            S_SUB: begin
                Gin        = 1'b1;
                RdY        = 1'b1;
                add_sub    = 1'b1;
                next_state = S_WRITE_X;
            end
            S_MV: begin
                Gin        = 1'b1;
                next_state = S_WRITE_X;
            end
            S_ADDI: begin
                Iout       = 1'b1;
                Gin        = 1'b1;
                next_state = S_WRITE_X;
            end
            S_SUBI: begin
                Iout       = 1'b1;
                Gin        = 1'b1;
                add_sub    = 1'b1;
                next_state = S_WRITE_X;
            end
            S_WRITE_X: begin
                Gout       = 1'b1;
                WrX        = 1'b1;
                next_state = S_FETCH;
            end
            S_DISP: begin
                DPin       = 1'b1;
                RdX        = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                RdX        = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

endmodule
